thermo_dco: RTL and testbench

Digitally controlled oscillator for the ADPLL loop. Consumes the thermometer-coded frequency word and the 3-bit divider select produced by the loop up/down counter. Generates the oscillator output `dcoOut` and a divided feedback clock `divOut` that returns to the phase detector. Runs on the fast system clock; both control inputs arrive from the `clkUD` domain and are resynchronised here.

---
 rtl/adpll_pkg.sv | 19 +
 rtl/sync_2ff.sv | 26 ++
 rtl/thermo_dco.sv | 129 ++++++++++++
 tb/tb_thermo_dco.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Constants and helper functions shared by the ADPLL loop blocks.
package adpll_pkg;

    localparam int COUNTER_SIZE = 16;
    localparam int DIV_SEL_W    = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // A thermometer code 0..01..1 plus one carries out of every set bit, leaving no overlap.
    function automatic logic is_thermo(input logic [63:0] word);
        return ((word & (word + 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for control signals crossing into the clkSys domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/thermo_dco.sv
// Thermometer-controlled DCO: half-period = BASE_PERIOD - popcount(word), with a
// power-of-two feedback divider whose select changes only at a counter wrap.
module thermo_dco
    import adpll_pkg::*;
#(
    parameter int counterSize = COUNTER_SIZE,
    parameter int MAX_DIV     = 8,
    parameter int BASE_PERIOD = 48
) (
    input  logic                   clkSys,
    input  logic                   reset,
    input  logic [counterSize-1:0] ctrlWord,
    input  logic [DIV_SEL_W-1:0]   divSelect,
    output logic                   dcoOut,
    output logic                   divOut,
    output logic                   thermoError
);

    localparam int ONES_W = clog2(counterSize + 1);
    localparam int HP_W   = clog2(BASE_PERIOD + 1);
    localparam int DIV_W  = MAX_DIV - 1;
    localparam logic [HP_W-1:0]      HP_BASE = HP_W'(BASE_PERIOD);
    localparam logic [DIV_SEL_W-1:0] SEL_MAX = DIV_SEL_W'(MAX_DIV - 1);

    logic [counterSize-1:0] ctrl_sync;
    logic [DIV_SEL_W-1:0]   div_sync;
    logic [ONES_W-1:0]      ones_count;
    logic [HP_W-1:0]        half_period_d, half_period_q;
    logic                   thermo_err_d, thermo_err_q;
    logic [HP_W-1:0]        period_cnt_d, period_cnt_q;
    logic                   dco_d, dco_q;
    logic [DIV_SEL_W-1:0]   div_prev_d, div_prev_q;
    logic [DIV_SEL_W-1:0]   div_sel_acc_d, div_sel_acc_q;
    logic [DIV_SEL_W-1:0]   sel_app_d, sel_app_q;
    logic [DIV_W-1:0]       div_count_d, div_count_q;
    logic                   div_out_d, div_out_q;
    logic                   dco_rise, div_wrap;

    sync_2ff #(.WIDTH(counterSize)) u_ctrl_sync (
        .clk (clkSys),
        .rst (reset),
        .d   (ctrlWord),
        .q   (ctrl_sync)
    );

    sync_2ff #(.WIDTH(DIV_SEL_W)) u_div_sync (
        .clk (clkSys),
        .rst (reset),
        .d   (divSelect),
        .q   (div_sync)
    );

    // Non-thermometer words are still decoded by popcount; only the flag reports them.
    always_comb begin
        ones_count = '0;
        for (int i = 0; i < counterSize; i++) begin
            ones_count = ones_count + ONES_W'(ctrl_sync[i]);
        end
        half_period_d = HP_BASE - HP_W'(ones_count);
        thermo_err_d  = ~is_thermo(64'(ctrl_sync));
    end

    // Reload only at a toggle, so a new frequency never truncates a half-cycle.
    always_comb begin
        period_cnt_d = period_cnt_q - HP_W'(1);
        dco_d        = dco_q;
        if (period_cnt_q == '0) begin
            period_cnt_d = half_period_q - HP_W'(1);
            dco_d        = ~dco_q;
        end
    end

    assign dco_rise = (period_cnt_q == '0) && !dco_q;
    assign div_wrap = dco_rise && (div_count_q == '1);

    always_comb begin
        div_prev_d    = div_sync;
        div_sel_acc_d = div_sel_acc_q;
        if (div_sync == div_prev_q) begin
            div_sel_acc_d = (int'(div_sync) >= MAX_DIV) ? SEL_MAX : div_sync;
        end
    end

    always_comb begin
        div_count_d = div_count_q;
        sel_app_d   = sel_app_q;
        if (dco_rise) begin
            div_count_d = div_count_q + DIV_W'(1);
        end
        if (div_wrap) begin
            sel_app_d = div_sel_acc_q;
        end
        div_out_d = dco_q;
        for (int i = 0; i < DIV_W; i++) begin
            if (int'(sel_app_q) == i + 1) begin
                div_out_d = div_count_q[i];
            end
        end
    end

    always_ff @(posedge clkSys or posedge reset) begin
        if (reset) begin
            half_period_q <= HP_BASE;
            thermo_err_q  <= 1'b0;
            period_cnt_q  <= HP_BASE - HP_W'(1);
            dco_q         <= 1'b0;
            div_prev_q    <= '0;
            div_sel_acc_q <= '0;
            sel_app_q     <= '0;
            div_count_q   <= '0;
            div_out_q     <= 1'b0;
        end else begin
            half_period_q <= half_period_d;
            thermo_err_q  <= thermo_err_d;
            period_cnt_q  <= period_cnt_d;
            dco_q         <= dco_d;
            div_prev_q    <= div_prev_d;
            div_sel_acc_q <= div_sel_acc_d;
            sel_app_q     <= sel_app_d;
            div_count_q   <= div_count_d;
            div_out_q     <= div_out_d;
        end
    end

    assign dcoOut      = dco_q;
    assign divOut      = div_out_q;
    assign thermoError = thermo_err_q;

endmodule

// File: tb/tb_thermo_dco.sv
// Bench for thermo_dco: half-period and divider-edge scoreboards plus table-driven control words.
module tb_thermo_dco;

    logic        clkSys = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ctrlWord = 16'h00F0;
    logic [2:0]  divSelect = 3'd0;
    logic [2:0]  divSel4 = 3'd0;
    logic        dcoOut, divOut, thermoError;
    logic        dcoOut4, divOut4, thermoError4;

    thermo_dco #(.counterSize(16), .MAX_DIV(8), .BASE_PERIOD(48)) u_dut (
        .clkSys      (clkSys),
        .reset       (reset),
        .ctrlWord    (ctrlWord),
        .divSelect   (divSelect),
        .dcoOut      (dcoOut),
        .divOut      (divOut),
        .thermoError (thermoError)
    );

    thermo_dco #(.counterSize(16), .MAX_DIV(4), .BASE_PERIOD(48)) u_dut4 (
        .clkSys      (clkSys),
        .reset       (reset),
        .ctrlWord    (ctrlWord),
        .divSelect   (divSel4),
        .dcoOut      (dcoOut4),
        .divOut      (divOut4),
        .thermoError (thermoError4)
    );

    always #5 clkSys = ~clkSys;

    int cyc = 0;
    always @(posedge clkSys) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    int exp_q[$];
    int dq0[$];
    int dq1[$];

    int tog_n = 0;
    int last_iv = 0;
    int allow_a = 48;
    int allow_b = 48;
    bit chk_lag = 1'b0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: measures dcoOut half-periods and divOut rise spacing, popping the scoreboards.
    initial begin
        int   iv;
        int   last_tog;
        int   last_r0;
        int   last_r1;
        logic dco_prev;
        logic d0_prev;
        logic d1_prev;
        last_tog = 0; last_r0 = 0; last_r1 = 0;
        dco_prev = 1'b0; d0_prev = 1'b0; d1_prev = 1'b0;
        forever begin
            @(negedge clkSys);
            if (reset) begin
                last_tog = cyc; last_r0 = cyc; last_r1 = cyc;
                dco_prev = 1'b0; d0_prev = 1'b0; d1_prev = 1'b0;
            end else begin
                if (dcoOut != dco_prev) begin
                    iv = cyc - last_tog;
                    last_tog = cyc;
                    last_iv = iv;
                    tog_n++;
                    if (exp_q.size() > 0) chk("half_period", iv, exp_q.pop_front());
                    else chk("half_period_in_transition", int'(iv == allow_a || iv == allow_b), 1);
                end
                if (chk_lag) chk("divout_lag", int'(divOut), int'(dco_prev));
                if (divOut && !d0_prev) begin
                    iv = cyc - last_r0;
                    last_r0 = cyc;
                    if (dq0.size() > 0) chk("div_rise_spacing", iv, dq0.pop_front());
                end
                if (divOut4 && !d1_prev) begin
                    iv = cyc - last_r1;
                    last_r1 = cyc;
                    if (dq1.size() > 0) chk("div4_clamp_rise_spacing", iv, dq1.pop_front());
                end
                dco_prev = dcoOut;
                d0_prev  = divOut;
                d1_prev  = divOut4;
            end
        end
    end

    task automatic wait_tog(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (tog_n < target && n < limit) begin
            @(negedge clkSys);
            n++;
        end
        chk(name, int'(tog_n >= target), 1);
    endtask

    task automatic wait_empty(input int limit, input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || dq0.size() > 0 || dq1.size() > 0) && n < limit) begin
            @(negedge clkSys);
            n++;
        end
        chk(name, exp_q.size() + dq0.size() + dq1.size(), 0);
    endtask

    typedef struct {
        logic [15:0] word;
        int          hp;
        logic        terr;
    } vec_t;

    vec_t        vecs[7];
    int          cur_hp;
    int          tgt;
    int          n;
    logic [15:0] w;

    initial begin
        vecs[0] = '{16'h7FFF, 33, 1'b0};
        vecs[1] = '{16'h00F0, 44, 1'b1};
        vecs[2] = '{16'hFFFF, 32, 1'b0};
        vecs[3] = '{16'h8000, 47, 1'b1};
        vecs[4] = '{16'h0001, 47, 1'b0};
        vecs[5] = '{16'h0000, 48, 1'b0};
        vecs[6] = '{16'h000F, 44, 1'b0};

        // Reset state, even with an invalid word presented at the input.
        repeat (3) @(negedge clkSys);
        chk("reset_dcoOut", int'(dcoOut), 0);
        chk("reset_divOut", int'(divOut), 0);
        chk("reset_thermoError", int'(thermoError), 0);
        chk("reset_dcoOut4", int'(dcoOut4), 0);
        chk("reset_divOut4", int'(divOut4), 0);
        chk("reset_thermoError4", int'(thermoError4), 0);
        ctrlWord = 16'h0000;
        #1 reset = 1'b0;

        // First rise BASE_PERIOD after release, then 96-cycle period; divOut trails by one.
        exp_q.push_back(48); exp_q.push_back(48); exp_q.push_back(48);
        chk_lag = 1'b1;
        wait_empty(400, "first_period_done");
        chk_lag = 1'b0;
        chk("thermoError_zero_word", int'(thermoError), 0);

        // Table: every transition keeps whole half-cycles, then settles on the new value.
        cur_hp = 48;
        for (int i = 0; i < 7; i++) begin
            @(negedge clkSys);
            allow_a = cur_hp;
            allow_b = vecs[i].hp;
            ctrlWord = vecs[i].word;
            tgt = tog_n + 3;
            wait_tog(tgt, 300, "table_transition_toggles");
            exp_q.push_back(vecs[i].hp);
            exp_q.push_back(vecs[i].hp);
            wait_empty(300, "table_settled_toggles");
            chk("table_thermoError", int'(thermoError), int'(vecs[i].terr));
            cur_hp = vecs[i].hp;
        end

        // thermoError latency of exactly three clocks, in both directions.
        allow_a = 44; allow_b = 44;
        @(negedge clkSys);
        ctrlWord = 16'h00F0;
        @(negedge clkSys); chk("terr_set_c1", int'(thermoError), 0);
        @(negedge clkSys); chk("terr_set_c2", int'(thermoError), 0);
        @(negedge clkSys); chk("terr_set_c3", int'(thermoError), 1);
        ctrlWord = 16'h000F;
        @(negedge clkSys); chk("terr_clr_c1", int'(thermoError), 1);
        @(negedge clkSys); chk("terr_clr_c2", int'(thermoError), 1);
        @(negedge clkSys); chk("terr_clr_c3", int'(thermoError), 0);

        // Walk the thermometer word up one bit every 200 cycles.
        allow_a = 44; allow_b = 48;
        ctrlWord = 16'h0000;
        repeat (200) @(negedge clkSys);
        chk("walk_hp_0", last_iv, 48);
        for (int k = 1; k <= 16; k++) begin
            w = 16'((32'd1 << k) - 32'd1);
            allow_a = 49 - k;
            allow_b = 48 - k;
            ctrlWord = w;
            repeat (200) @(negedge clkSys);
            chk("walk_half_period", last_iv, 48 - k);
            chk("walk_thermoError", int'(thermoError), 0);
        end

        // Divider: select 3 (and 7 clamped to 3 on the MAX_DIV=4 instance) waits for a wrap.
        @(negedge clkSys);
        reset = 1'b1;
        ctrlWord = 16'h0000;
        divSelect = 3'd0;
        divSel4 = 3'd0;
        allow_a = 48; allow_b = 48;
        repeat (3) @(negedge clkSys);
        #1 reset = 1'b0;
        dq0.push_back(49);
        for (int i = 0; i < 126; i++) dq0.push_back(96);
        dq0.push_back(480); dq0.push_back(768); dq0.push_back(768);
        dq1.push_back(49);
        for (int i = 0; i < 6; i++) dq1.push_back(96);
        dq1.push_back(480); dq1.push_back(768); dq1.push_back(768);
        @(negedge clkSys);
        divSelect = 3'd3;
        divSel4 = 3'd7;
        wait_empty(15000, "divider_sequence_done");

        // Asynchronous reset mid half-period while both outputs are high.
        divSelect = 3'd2;
        n = 0;
        while (!(dcoOut && divOut) && n < 1000) begin
            @(negedge clkSys);
            n++;
        end
        chk("outputs_high_before_reset", int'(dcoOut && divOut), 1);
        @(posedge clkSys);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_dcoOut", int'(dcoOut), 0);
        chk("async_reset_divOut", int'(divOut), 0);
        repeat (2) @(negedge clkSys);
        #1 reset = 1'b0;
        exp_q.push_back(48); exp_q.push_back(48); exp_q.push_back(48);
        dq0.push_back(49); dq0.push_back(96);
        chk_lag = 1'b1;
        wait_empty(400, "restart_sequence_done");
        chk_lag = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
